// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: data-memory req/gnt + rvalid handshake, upstream stall and the MEM/WB register.
// Optional access timeout with bus_err reporting is built only when MEM_TIMEOUT_EN is defined.
module mem_stage_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ctrl_mem,
    input  logic [31:0] rd_mem,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data1,
    input  logic [31:0] pc4_mem,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [2:0]  ctrl_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] wb_data,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] load_buf_q, load_buf_d;
    logic [2:0]  ctrl_wb_q;
    logic [4:0]  rd_wb_q;
    logic [31:0] wb_data_q;

    logic        reg_write, mem_read, mem_write, access, is_store;
    logic [1:0]  wb_sel;
    logic        stall_c, req_c, wb_load, abort_c;
    logic        tmo_hit, aborted;
    logic [31:0] wb_data_c;

    assign reg_write = ctrl_mem[4];
    assign wb_sel    = ctrl_mem[3:2];
    assign mem_read  = ctrl_mem[1];
    assign mem_write = ctrl_mem[0];
    assign access    = mem_read | mem_write;
    assign is_store  = mem_write & ~mem_read;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        stall_c    = 1'b0;
        req_c      = 1'b0;
        wb_load    = 1'b0;
        abort_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall_c = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    wb_load = 1'b1;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                // A completing handshake on the last allowed cycle beats the timeout.
                if (dmem_gnt && (is_store || dmem_rvalid)) begin
                    if (!is_store) begin
                        load_buf_d = dmem_rdata;
                    end
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    abort_c = 1'b1;
                    state_d = ST_DONE;
                end else if (dmem_gnt) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                stall_c = 1'b1;
                if (dmem_rvalid) begin
                    load_buf_d = dmem_rdata;
                    state_d    = ST_DONE;
                end else if (tmo_hit) begin
                    abort_c = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                wb_load = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (wb_sel)
            2'b01:   wb_data_c = load_buf_q;
            2'b10:   wb_data_c = pc4_mem;
            default: wb_data_c = alu_result;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            load_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
        end
    end

    // While the stage is busy the MEM/WB register carries a bubble and holds rd/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_wb_q <= '0;
            rd_wb_q   <= '0;
            wb_data_q <= '0;
        end else if (wb_load) begin
            ctrl_wb_q <= {reg_write & ~aborted, wb_sel};
            rd_wb_q   <= rd_mem[4:0];
            wb_data_q <= wb_data_c;
        end else begin
            ctrl_wb_q <= '0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aborted_q;
    logic             bus_err_q;

    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign aborted = aborted_q;
    assign bus_err = bus_err_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == ST_REQ) || (state_q == ST_RESP)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= (state_q == ST_DONE) && aborted_q;
            if (abort_c) begin
                aborted_q <= 1'b1;
            end else if (state_q == ST_DONE) begin
                aborted_q <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign aborted    = 1'b0;
    assign bus_err    = 1'b0;
    assign unused_cfg = ^{abort_c, TIMEOUT_CYCLES[0]};
`endif

    logic unused_rd;
    assign unused_rd = ^rd_mem[31:5];

    // Stall is combinational from the inputs in IDLE, so it is masked while reset is held.
    assign stall      = stall_c & ~reset;
    assign dmem_req   = req_c;
    assign dmem_we    = req_c & is_store;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = write_data1;
    assign ctrl_wb    = ctrl_wb_q;
    assign rd_wb      = rd_wb_q;
    assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: transaction-level model plus literal spot checks.
// Define MEM_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_mem_stage_unit;

    localparam int T = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  ctrl_mem;
    logic [31:0] rd_mem, alu_result, write_data1, pc4_mem;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [2:0]  ctrl_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Per-cycle expectations and the architectural MEM/WB model.
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] cur_alu, cur_wd;
    logic [2:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_loadbuf;
    logic        m_err;
    int          stall_seen, req_seen;

    mem_stage_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_mem    (ctrl_mem),
        .rd_mem      (rd_mem),
        .alu_result  (alu_result),
        .write_data1 (write_data1),
        .pc4_mem     (pc4_mem),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .ctrl_wb     (ctrl_wb),
        .rd_wb       (rd_wb),
        .wb_data     (wb_data),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, exp_stall);
            check("dmem_req", dmem_req, exp_req);
            check("dmem_we", dmem_we, exp_we);
            if (exp_req) begin
                check("dmem_addr", dmem_addr, cur_alu);
                check("dmem_wdata", dmem_wdata, cur_wd);
            end
            check("ctrl_wb", ctrl_wb, m_ctrl);
            check("rd_wb", rd_wb, m_rd);
            check("wb_data", wb_data, m_data);
            check("bus_err", bus_err, m_err);
            stall_seen += int'(stall);
            req_seen   += int'(dmem_req);
        end
    end

    // One instruction through MEM: w = non-granted REQ cycles, r = cycles from gnt to rvalid (loads).
    // noise drives gnt/rvalid (and wrong rdata) wherever the handshake must be ignored.
    task automatic run_instr(input logic [4:0] ctrl, input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] pc4, input int w, input int r,
                             input logic [31:0] rdat, input bit noise);
        bit acc, ld, st, ab;
        int busy, ncyc, req_end;
        ld  = ctrl[1];
        acc = ctrl[1] | ctrl[0];
        st  = ctrl[0] & ~ctrl[1];
        ctrl_mem    = ctrl;
        rd_mem      = {27'($urandom()), rd};
        alu_result  = alu;
        write_data1 = wd;
        pc4_mem     = pc4;
        cur_alu     = alu;
        cur_wd      = wd;
        if (!acc) begin
            busy = 0;
            ab   = 1'b0;
            ncyc = 1;
        end else begin
            busy = w + 1 + (ld ? r : 0);
            ab   = TMO && (busy > T);
            if (ab) busy = T;
            ncyc = busy + 2;
        end
        req_end    = (w + 1 < busy) ? w + 1 : busy;
        stall_seen = 0;
        req_seen   = 0;
        for (int c = 0; c < ncyc; c++) begin
            exp_stall   = acc && (c < ncyc - 1);
            exp_req     = acc && (c >= 1) && (c <= req_end);
            exp_we      = exp_req && st;
            dmem_gnt    = acc && (c == w + 1);
            dmem_rvalid = ld && (c == w + 1 + r);
            dmem_rdata  = rdat;
            if (noise) begin
                if (c == 0 || c == ncyc - 1) begin
                    dmem_gnt    = 1'b1;
                    dmem_rvalid = 1'b1;
                end else if (c < w + 1) begin
                    dmem_rvalid = 1'b1;
                end else if (c > w + 1) begin
                    dmem_gnt = 1'b1;
                end else if (st) begin
                    dmem_rvalid = 1'b1;
                end
                if (!(ld && c == w + 1 + r)) dmem_rdata = ~rdat;
            end
            @(posedge clk);
            if (c == ncyc - 1) begin
                if (ld && !ab) m_loadbuf = rdat;
                case (ctrl[3:2])
                    2'b01:   m_data = m_loadbuf;
                    2'b10:   m_data = pc4;
                    default: m_data = alu;
                endcase
                m_ctrl = {ctrl[4] & ~ab, ctrl[3:2]};
                m_rd   = rd;
                m_err  = ab;
            end else begin
                m_ctrl = 3'b000;
                m_err  = 1'b0;
            end
            #1;
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        ctrl_mem    = '0;
        rd_mem      = '0;
        alu_result  = '0;
        write_data1 = '0;
        pc4_mem     = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        m_ctrl      = '0;
        m_rd        = '0;
        m_data      = '0;
        m_loadbuf   = '0;
        m_err       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl_wb", ctrl_wb, 32'd0);
        check("rst_rd_wb", rd_wb, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_req", dmem_req, 32'd0);
        check("rst_bus_err", bus_err, 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_instr(5'b10000, 5'd3, 32'h0000_0005, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0);
        check("alu_ctrl_wb", ctrl_wb, 32'b100);
        check("alu_rd_wb", rd_wb, 32'd3);
        check("alu_wb_data", wb_data, 32'd5);
        check("alu_stall_cycles", stall_seen, 32'd0);

        run_instr(5'b00001, 5'd9, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 0, 32'h0, 1'b1);
        check("st_stall_cycles", stall_seen, 32'd5);
        check("st_req_cycles", req_seen, 32'd4);
        check("st_ctrl_wb", ctrl_wb, 32'd0);

        run_instr(5'b10110, 5'd7, 32'h0000_0200, 32'h0, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
        check("ld_stall_cycles", stall_seen, 32'd2);
        check("ld_wb_data", wb_data, 32'h1234_5678);
        check("ld_rd_wb", rd_wb, 32'd7);
        check("ld_ctrl_wb", ctrl_wb, 32'b101);

        run_instr(5'b10110, 5'd12, 32'h0000_0300, 32'h0, 32'h0, 1, 2, 32'hA5A5_0F0F, 1'b1);
        check("ld2_stall_cycles", stall_seen, 32'd5);
        check("ld2_wb_data", wb_data, 32'hA5A5_0F0F);

        run_instr(5'b10111, 5'd13, 32'h0000_0400, 32'hFFFF_0000, 32'h0, 0, 0, 32'h0BAD_CAFE, 1'b0);
        check("ldst_wb_data", wb_data, 32'h0BAD_CAFE);

        run_instr(5'b11000, 5'd1, 32'h0000_0999, 32'h0, 32'h0000_0044, 0, 0, 32'h0, 1'b1);
        check("jal_wb_data", wb_data, 32'h44);
        check("jal_ctrl_wb", ctrl_wb, 32'b110);
        check("jal_req_cycles", req_seen, 32'd0);

        run_instr(5'b11100, 5'd2, 32'h0000_0077, 32'h0, 32'h0000_0088, 0, 0, 32'h0, 1'b0);
        check("sel11_wb_data", wb_data, 32'h77);

        // Reset while a load waits in RESP.
        chk_en     = 1'b0;
        ctrl_mem   = 5'b10110;
        rd_mem     = 32'd9;
        alu_result = 32'h0000_0500;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        @(posedge clk);
        #1;
        check("resp_stall", stall, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_stall", stall, 32'd0);
        check("arst_req", dmem_req, 32'd0);
        check("arst_ctrl_wb", ctrl_wb, 32'd0);
        check("arst_rd_wb", rd_wb, 32'd0);
        check("arst_wb_data", wb_data, 32'd0);
        check("arst_bus_err", bus_err, 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_ctrl    = '0;
        m_rd      = '0;
        m_data    = '0;
        m_loadbuf = '0;
        m_err     = 1'b0;
        chk_en    = 1'b1;

        run_instr(5'b10000, 5'd21, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1);
        check("post_rst_wb_data", wb_data, 32'h1234);
        check("post_rst_rd_wb", rd_wb, 32'd21);

        run_instr(5'b10100, 5'd4, 32'h0000_0666, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0);
        check("rst_loadbuf", wb_data, 32'd0);
        check("rst_loadbuf_ctrl", ctrl_wb, 32'b101);

        // Load that is never granted inside the timeout window.
        run_instr(5'b10110, 5'd5, 32'h0000_0700, 32'h0, 32'h0, 150, 0, 32'h5555_AAAA, 1'b1);
        if (TMO) begin
            check("tmo_stall_cycles", stall_seen, 32'd5);
            check("tmo_bus_err", bus_err, 32'd1);
            check("tmo_ctrl_wb", ctrl_wb, 32'b001);
        end else begin
            check("long_stall", 32'(stall_seen > 100), 32'd1);
            check("long_bus_err", bus_err, 32'd0);
            check("long_wb_data", wb_data, 32'h5555_AAAA);
        end

        run_instr(5'b10000, 5'd30, 32'h0000_00C3, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0);
        check("final_wb_data", wb_data, 32'hC3);
        check("final_ctrl_wb", ctrl_wb, 32'b100);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
